sobel_window_gen: RTL and testbench

- Producer side of the 3x3 window bus consumed by sobel_op.
- Accepts a raster-order 8-bit grayscale pixel stream, one pixel per handshake.
- Buffers the two previous image rows in line buffers and holds a 3x3 shift window.
- Emits one packed 72-bit window per input pixel whose window lies fully inside the frame.
- Sits between the pixel source FIFO and sobel_op in the edge-detection pipeline.

---
 rtl/sobel_pkg.sv | 15 +
 rtl/sobel_window_gen_if.sv | 29 ++
 rtl/sobel_line_buffer.sv | 25 ++
 rtl/sobel_window_gen.sv | 117 +++++++++++
 tb/tb_sobel_window_gen.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and window indexing for the Sobel pipeline.
package sobel_pkg;

    localparam int unsigned PIXEL_W        = 8;
    localparam int unsigned WIN_DIM        = 3;
    localparam int unsigned WIN_W          = WIN_DIM * WIN_DIM * PIXEL_W;
    localparam int unsigned IMG_WIDTH_DEF  = 720;
    localparam int unsigned IMG_HEIGHT_DEF = 540;

    // Flat element index of window position (r, c); r=0 top row, c=0 left column.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out handshake bundle of the window generator.
interface sobel_window_gen_if
    import sobel_pkg::*;
#(
    parameter int unsigned DWIDTH_IN  = PIXEL_W,
    parameter int unsigned DWIDTH_OUT = WIN_W
);

    logic [DWIDTH_IN-1:0]  in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DWIDTH_OUT-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    // Window generator side.
    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    // Pixel source / window sink side.
    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// Single-port line buffer: combinational read of the addressed word, write on the clock edge,
// so a read and write to the same address in one cycle returns the old contents.
module sobel_line_buffer #(
    parameter int unsigned DEPTH = 720,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 pixel windows from a raster pixel stream using two line buffers
// and emits one packed window per pixel whose window lies fully inside the frame.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned DWIDTH_IN  = PIXEL_W,
    parameter int unsigned DWIDTH_OUT = WIN_W,
    parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    sobel_window_gen_if.master bus
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic [DWIDTH_IN-1:0]  win_q [WIN_DIM][WIN_DIM];
    logic [DWIDTH_IN-1:0]  win_d [WIN_DIM][WIN_DIM];
    logic [DWIDTH_IN-1:0]  lb0_rd;
    logic [DWIDTH_IN-1:0]  lb1_rd;
    logic [DWIDTH_OUT-1:0] win_packed;
    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic                  emit;

    // Single output stage: accept whenever the held window is empty or leaving.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));
    // Three fresh columns and three rows are needed before a window is complete.
    assign emit     = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    // lb0 holds the previous row; lb1 holds the row before that.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DWIDTH_IN)
    ) u_lb0 (
        .clock   (clock),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (bus.in_data),
        .rd_data (lb0_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DWIDTH_IN)
    ) u_lb1 (
        .clock   (clock),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Next window: shift columns left and insert the new column on accept.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int unsigned r = 0; r < WIN_DIM; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = bus.in_data;
        end
    end

    // Pack the next window, element (r,c) at slot r*3+c.
    always_comb begin
        win_packed = '0;
        for (int unsigned r = 0; r < WIN_DIM; r++) begin
            for (int unsigned c = 0; c < WIN_DIM; c++) begin
                win_packed[win_idx(r, c) * DWIDTH_IN +: DWIDTH_IN] = win_d[r][c];
            end
        end
    end

    // Raster counters, window registers and the registered output stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q         <= '0;
            row_q         <= '0;
            win_q         <= '{default: '0};
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            win_q <= win_d;
            if (accept) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
                bus.out_valid <= emit;
                bus.out_last  <= emit && col_last && row_last;
                if (emit) begin
                    bus.out_data <= win_packed;
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench: directed 4x3 frames plus randomized throttling on an 8x5 frame,
// checked against a window model computed directly from stored frame pixels.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int unsigned AW = 4;
    localparam int unsigned AH = 3;
    localparam int unsigned BW = 8;
    localparam int unsigned BH = 5;
    localparam logic [71:0] LIT0 = 72'h0A0908060504020100;
    localparam logic [71:0] LIT1 = 72'h0B0A09070605030201;

    typedef struct {
        logic [71:0] data;
        logic        last;
    } win_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    sobel_window_gen_if #(.DWIDTH_IN(8), .DWIDTH_OUT(72)) if_a ();
    sobel_window_gen_if #(.DWIDTH_IN(8), .DWIDTH_OUT(72)) if_b ();

    sobel_window_gen #(
        .DWIDTH_IN (8), .DWIDTH_OUT (72), .IMG_WIDTH (AW), .IMG_HEIGHT (AH)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (if_a.master)
    );

    sobel_window_gen #(
        .DWIDTH_IN (8), .DWIDTH_OUT (72), .IMG_WIDTH (BW), .IMG_HEIGHT (BH)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (if_b.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] frm [0:BH-1][0:BW-1];
    win_t exp_a[$];
    win_t exp_b[$];
    win_t rx_a[$];
    logic stall_a = 1'b0;
    logic stall_b = 1'b0;
    win_t hold_a;
    win_t hold_b;
    int   b_in_frame = 0;
    int   b_frames   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Model: the window whose bottom-right pixel is frame position (r, c).
    function automatic logic [71:0] window_at(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[8 * (i * 3 + j) +: 8] = frm[r - 2 + i][c - 2 + j];
            end
        end
        return w;
    endfunction

    // Queue every window the current frame must produce, in raster order.
    task automatic push_expected(input bit which, input int w, input int h);
        win_t item;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                item.data = window_at(r, c);
                item.last = (r == h - 1) && (c == w - 1);
                if (which) exp_b.push_back(item);
                else       exp_a.push_back(item);
            end
        end
    endtask

    // Per-cycle output checks for both instances, sampled at the falling edge.
    task automatic compare_cycle();
        win_t e;
        win_t cur;
        if (reset) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
            return;
        end
        cur.data = if_a.out_data;
        cur.last = if_a.out_last;
        check("a_in_ready", if_a.in_ready, !(if_a.out_valid && !if_a.out_ready));
        if (stall_a) begin
            check("a_hold_valid", if_a.out_valid, 1'b1);
            check("a_hold_data", cur.data, hold_a.data);
            check("a_hold_last", cur.last, hold_a.last);
        end
        if (if_a.out_valid && if_a.out_ready) begin
            check("a_window_expected", exp_a.size() != 0, 1'b1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                check("a_window_data", cur.data, e.data);
                check("a_window_last", cur.last, e.last);
            end
            rx_a.push_back(cur);
        end
        stall_a = if_a.out_valid && !if_a.out_ready;
        hold_a  = cur;

        cur.data = if_b.out_data;
        cur.last = if_b.out_last;
        check("b_in_ready", if_b.in_ready, !(if_b.out_valid && !if_b.out_ready));
        if (stall_b) begin
            check("b_hold_valid", if_b.out_valid, 1'b1);
            check("b_hold_data", cur.data, hold_b.data);
            check("b_hold_last", cur.last, hold_b.last);
        end
        if (if_b.out_valid && if_b.out_ready) begin
            check("b_window_expected", exp_b.size() != 0, 1'b1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                check("b_window_data", cur.data, e.data);
                check("b_window_last", cur.last, e.last);
            end
            b_in_frame++;
            if (cur.last) begin
                check("b_frame_window_count", b_in_frame, (BW - 2) * (BH - 2));
                b_in_frame = 0;
                b_frames++;
            end
        end
        stall_b = if_b.out_valid && !if_b.out_ready;
        hold_b  = cur;
    endtask

    // One clock: sample at the falling edge, then return just after the rising edge.
    task automatic tick(output logic ra, output logic rb);
        @(negedge clock);
        ra = if_a.in_ready;
        rb = if_b.in_ready;
        compare_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        logic ra, rb;
        repeat (n) tick(ra, rb);
    endtask

    // Present one pixel to instance A and hold it until accepted.
    task automatic send_a(input logic [7:0] px);
        logic ra, rb;
        ra = 1'b0;
        if_a.in_valid = 1'b1;
        if_a.in_data  = px;
        for (int n = 0; n < 64 && !ra; n++) tick(ra, rb);
        if (!ra) check("a_accept_timeout", ra, 1'b1);
    endtask

    task automatic send_frame_a();
        for (int p = 0; p < int'(AW * AH); p++) send_a(8'(p));
        if_a.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_a.delete();
        exp_b.delete();
        idle(2);
        check("rst_a_out_valid", if_a.out_valid, 1'b0);
        check("rst_b_out_valid", if_b.out_valid, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic ra, rb;
        int idx;
        int guard;

        reset          = 1'b1;
        if_a.in_valid  = 1'b0;
        if_a.in_data   = '0;
        if_a.out_ready = 1'b1;
        if_b.in_valid  = 1'b0;
        if_b.in_data   = '0;
        if_b.out_ready = 1'b1;

        // Reset state.
        idle(2);
        check("rst_out_valid", if_a.out_valid, 1'b0);
        check("rst_out_last", if_a.out_last, 1'b0);
        check("rst_out_data", if_a.out_data, 72'h0);
        reset = 1'b0;
        idle(1);

        // Directed frame pixels = row*4+col; pin the model to the known windows.
        for (int r = 0; r < int'(AH); r++)
            for (int c = 0; c < int'(AW); c++)
                frm[r][c] = 8'(r * 4 + c);
        check("model_win0", window_at(2, 2), LIT0);
        check("model_win1", window_at(2, 3), LIT1);

        // Streaming with out_ready held high.
        rx_a.delete();
        push_expected(1'b0, AW, AH);
        send_frame_a();
        idle(4);
        check("stream_count", rx_a.size(), 2);
        if (rx_a.size() >= 2) begin
            check("stream_w0", rx_a[0].data, LIT0);
            check("stream_w0_last", rx_a[0].last, 1'b0);
            check("stream_w1", rx_a[1].data, LIT1);
            check("stream_w1_last", rx_a[1].last, 1'b1);
        end

        // Backpressure for 5 cycles after the first window.
        rx_a.delete();
        push_expected(1'b0, AW, AH);
        if_a.out_ready = 1'b0;
        for (int p = 0; p < 11; p++) send_a(8'(p));
        if_a.in_data = 8'd11;
        repeat (5) begin
            tick(ra, rb);
            check("stall_in_ready", ra, 1'b0);
            check("stall_out_valid", if_a.out_valid, 1'b1);
            check("stall_out_data", if_a.out_data, LIT0);
        end
        if_a.out_ready = 1'b1;
        send_a(8'd11);
        if_a.in_valid = 1'b0;
        idle(4);
        check("stall_count", rx_a.size(), 2);
        if (rx_a.size() >= 2) begin
            check("stall_w0", rx_a[0].data, LIT0);
            check("stall_w1", rx_a[1].data, LIT1);
            check("stall_w1_last", rx_a[1].last, 1'b1);
        end

        // Two back-to-back frames.
        rx_a.delete();
        push_expected(1'b0, AW, AH);
        push_expected(1'b0, AW, AH);
        send_frame_a();
        send_frame_a();
        idle(4);
        check("b2b_count", rx_a.size(), 4);
        if (rx_a.size() >= 4) begin
            check("b2b_w2", rx_a[2].data, LIT0);
            check("b2b_w3", rx_a[3].data, LIT1);
            for (int i = 0; i < 4; i++) check("b2b_last", rx_a[i].last, (i % 2) == 1);
        end

        // Reset part-way through a frame, then a clean frame.
        for (int p = 0; p < 7; p++) send_a(8'(p));
        if_a.in_valid = 1'b0;
        do_reset();
        rx_a.delete();
        push_expected(1'b0, AW, AH);
        send_frame_a();
        idle(4);
        check("rst_mid_count", rx_a.size(), 2);
        if (rx_a.size() >= 2) begin
            check("rst_mid_w0", rx_a[0].data, LIT0);
            check("rst_mid_w1", rx_a[1].data, LIT1);
            check("rst_mid_w1_last", rx_a[1].last, 1'b1);
        end
        check("a_leftover", exp_a.size(), 0);

        // Randomized throttling over 20 frames on the 8x5 instance.
        b_in_frame = 0;
        b_frames   = 0;
        for (int f = 0; f < 20; f++) begin
            for (int r = 0; r < int'(BH); r++)
                for (int c = 0; c < int'(BW); c++)
                    frm[r][c] = 8'($urandom);
            push_expected(1'b1, BW, BH);
            idx   = 0;
            guard = 0;
            while (idx < int'(BW * BH) && guard < 2000) begin
                if (!if_b.in_valid && $urandom_range(0, 3) != 0) begin
                    if_b.in_valid = 1'b1;
                    if_b.in_data  = frm[idx / int'(BW)][idx % int'(BW)];
                end
                if_b.out_ready = ($urandom_range(0, 3) != 0);
                tick(ra, rb);
                if (if_b.in_valid && rb) begin
                    idx++;
                    if_b.in_valid = 1'b0;
                end
                guard++;
            end
            if (idx != int'(BW * BH)) check("b_frame_timeout", idx, BW * BH);
        end
        if_b.in_valid  = 1'b0;
        if_b.out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_b.size() != 0; n++) idle(1);
        idle(2);
        check("b_all_windows_seen", exp_b.size(), 0);
        check("b_frames_seen", b_frames, 20);
        check("b_partial_frame", b_in_frame, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
